// File: rtl/lsu_controller_if.sv
// Request/response and data-memory signal bundle for the load/store sequencer.
// slave = controller side, master = core plus data memory side.
interface lsu_controller_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [2:0]  ReqFunct3;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespFault;
  logic        MemWriteEnable;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;

  modport slave (
    input  ReqValid, ReqWrite, ReqFunct3, ReqAddr, ReqWData, MemReadData,
    output ReqReady, RespValid, RespData, RespFault,
    output MemWriteEnable, MemAddr, MemWriteData
  );

  modport master (
    output ReqValid, ReqWrite, ReqFunct3, ReqAddr, ReqWData, MemReadData,
    input  ReqReady, RespValid, RespData, RespFault,
    input  MemWriteEnable, MemAddr, MemWriteData
  );
endinterface

// File: rtl/lsu_controller.sv
// Load/store sequencer for a word-only data memory: RISC-V byte/half/word
// loads with extension, sub-word stores as read-modify-write.
module lsu_controller #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  lsu_controller_if.slave   bus
);

  // Aliasing is done by the memory indexing Addr[log2(DEPTH)+1:2]; only the depth shape matters here.
  if ((DEPTH_WORDS < 1) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_depth_check
    $error("lsu_controller: DEPTH_WORDS must be a power of two");
  end

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic        r_fault;

  logic        w_legal;
  logic        w_misaligned;
  logic        w_fault;
  logic [31:0] w_merge;
  logic [31:0] w_store_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;

  always_comb begin
    w_legal      = 1'b0;
    w_misaligned = 1'b0;
    if (bus.ReqWrite) begin
      w_legal = (bus.ReqFunct3 == 3'b000) || (bus.ReqFunct3 == 3'b001) ||
                (bus.ReqFunct3 == 3'b010);
    end else begin
      w_legal = (bus.ReqFunct3 == 3'b000) || (bus.ReqFunct3 == 3'b001) ||
                (bus.ReqFunct3 == 3'b010) || (bus.ReqFunct3 == 3'b100) ||
                (bus.ReqFunct3 == 3'b101);
    end
    if (bus.ReqFunct3[1:0] == 2'b01) begin
      w_misaligned = bus.ReqAddr[0];
    end else if (bus.ReqFunct3[1:0] == 2'b10) begin
      w_misaligned = (bus.ReqAddr[1:0] != 2'b00);
    end
    w_fault = !w_legal || w_misaligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_buf    <= 32'h0;
      r_fault  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && bus.ReqValid) begin
        r_write  <= bus.ReqWrite;
        r_funct3 <= bus.ReqFunct3;
        r_addr   <= bus.ReqAddr;
        r_wdata  <= bus.ReqWData;
        r_fault  <= w_fault;
      end
      if ((r_state == LOAD) || (r_state == RMW_READ)) begin
        r_buf <= bus.MemReadData;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.ReqValid) begin
          if (w_fault)                          w_state_next = RESP;
          else if (!bus.ReqWrite)               w_state_next = LOAD;
          else if (bus.ReqFunct3[1:0] == 2'b10) w_state_next = WRITE;
          else                                  w_state_next = RMW_READ;
        end
      end
      LOAD:     w_state_next = RESP;
      RMW_READ: w_state_next = WRITE;
      WRITE:    w_state_next = RESP;
      RESP:     w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // Per-lane merge of the store data into the word read back in RMW_READ.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       w_hit;
    logic [7:0] w_new;
    assign w_hit = ((r_funct3[1:0] == 2'b00) && (r_addr[1:0] == 2'(gi))) ||
                   ((r_funct3[1:0] == 2'b01) && (r_addr[1] == 1'(gi / 2)));
    assign w_new = (r_funct3[1:0] == 2'b00) ? r_wdata[7:0] : r_wdata[8*(gi%2) +: 8];
    assign w_merge[8*gi +: 8] = w_hit ? w_new : r_buf[8*gi +: 8];
  end

  assign w_store_data = (r_funct3[1:0] == 2'b10) ? r_wdata : w_merge;

  always_comb begin
    w_byte     = r_buf[{r_addr[1:0], 3'b000} +: 8];
    w_half     = r_addr[1] ? r_buf[31:16] : r_buf[15:0];
    w_load_ext = 32'h0;
    case (r_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_ext = r_buf;
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = 32'h0;
    endcase
  end

  // Every output is forced quiet while reset is high, including a write in flight.
  always_comb begin
    bus.ReqReady       = (r_state == IDLE) && !reset;
    bus.RespValid      = 1'b0;
    bus.RespData       = 32'h0;
    bus.RespFault      = 1'b0;
    bus.MemWriteEnable = 1'b0;
    bus.MemAddr        = 32'h0;
    bus.MemWriteData   = 32'h0;
    if (!reset) begin
      case (r_state)
        LOAD, RMW_READ: begin
          bus.MemAddr = {r_addr[31:2], 2'b00};
        end
        WRITE: begin
          bus.MemAddr        = {r_addr[31:2], 2'b00};
          bus.MemWriteEnable = 1'b1;
          bus.MemWriteData   = w_store_data;
        end
        RESP: begin
          bus.RespValid = 1'b1;
          bus.RespFault = r_fault;
          bus.RespData  = (r_write || r_fault) ? 32'h0 : w_load_ext;
        end
        default: begin
          bus.MemAddr = 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller with a word-wide data memory model
// indexed by MemAddr[11:2] (1024 words).
module tb_lsu_controller;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   acc_cnt = 0;

  always #5 clk = ~clk;

  lsu_controller_if bus();

  lsu_controller #(.DEPTH_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] mem [1024];
  assign bus.MemReadData = mem[bus.MemAddr[11:2]];
  always @(posedge clk) begin
    if (bus.MemWriteEnable) mem[bus.MemAddr[11:2]] <= bus.MemWriteData;
  end
  always @(posedge clk) begin
    if (bus.ReqValid && bus.ReqReady) acc_cnt <= acc_cnt + 1;
  end

  // Issues one request from an IDLE cycle, scrambles the inputs after acceptance and
  // records latency (cycle 1 = first cycle after the accept edge) and write activity.
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata,
                        output logic rfault, output int lat, output int we_cyc,
                        output int we_cnt, output logic [31:0] we_addr,
                        output logic [31:0] we_data);
    int  guard;
    int  c;
    bit  done;
    rdata = '0; rfault = 1'b0; lat = -1; we_cyc = -1; we_cnt = 0;
    we_addr = '0; we_data = '0;
    guard = 0;
    while (!bus.ReqReady && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.ReqValid = 1'b1; bus.ReqWrite = w; bus.ReqFunct3 = f3;
    bus.ReqAddr = a; bus.ReqWData = d;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0; bus.ReqWrite = ~w; bus.ReqFunct3 = 3'b111;
    bus.ReqAddr = 32'hFFFF_FFFF; bus.ReqWData = 32'hFFFF_FFFF;
    done = 1'b0;
    c = 1;
    while (!done && c <= 8) begin
      if (bus.MemWriteEnable) begin
        we_cnt++;
        if (we_cyc < 0) begin
          we_cyc = c; we_addr = bus.MemAddr; we_data = bus.MemWriteData;
        end
      end
      if (bus.RespValid) begin
        lat = c; rdata = bus.RespData; rfault = bus.RespFault; done = 1'b1;
      end
      @(posedge clk); #1;
      c++;
    end
    $display("[TB] %s f3=%b addr=%h wdata=%h -> lat=%0d data=%h fault=%b writes=%0d",
             w ? "STORE" : "LOAD ", f3, a, d, lat, rdata, rfault, we_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqFunct3 = 3'b010;
    bus.ReqAddr = 32'h4; bus.ReqWData = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (bus.ReqReady !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_ready: got %b want 0", bus.ReqReady);
    end
    tests++;
    if ({bus.RespValid, bus.RespFault, bus.RespData, bus.MemWriteEnable,
         bus.MemAddr, bus.MemWriteData} !== 99'h0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: rv=%b rf=%b rd=%h we=%b ma=%h wd=%h want all 0",
               bus.RespValid, bus.RespFault, bus.RespData, bus.MemWriteEnable,
               bus.MemAddr, bus.MemWriteData);
    end
    bus.ReqValid = 1'b0;
    reset = 1'b0;
    #1;
    tests++;
    if (bus.ReqReady !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_release_ready: got %b want 1", bus.ReqReady);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] rd, wa, wd;
    logic        rf;
    int          lat, wc, wn;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (lat !== 2 || wc !== 1 || wn !== 1 || wa !== 32'h10 || wd !== 32'hDEAD_BEEF) begin
      fails++;
      $display("[TB] FAIL sw_word: lat=%0d we_cyc=%0d we_cnt=%0d addr=%h data=%h want 2 1 1 00000010 deadbeef",
               lat, wc, wn, wa, wd);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'hDEAD_BEEF || rf !== 1'b0 || lat !== 2 || wn !== 0) begin
      fails++;
      $display("[TB] FAIL lw_word: data=%h fault=%b lat=%0d writes=%0d want deadbeef 0 2 0",
               rd, rf, lat, wn);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd, wa, wd;
    logic        rf;
    int          lat, wc, wn;
    do_req(1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, rf, lat, wc, wn, wa, wd);
    do_req(1'b1, 3'b000, 32'h21, 32'h0000_00AA, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (lat !== 3 || wc !== 2 || wn !== 1 || wa !== 32'h20 || rf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL sb_timing: lat=%0d we_cyc=%0d we_cnt=%0d addr=%h fault=%b want 3 2 1 00000020 0",
               lat, wc, wn, wa, rf);
    end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'h1122_AA44) begin
      fails++; $display("[TB] FAIL sb_merge: got %h want 1122aa44", rd);
    end
    do_req(1'b1, 3'b001, 32'h22, 32'h0000_5566, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (lat !== 3 || wc !== 2) begin
      fails++; $display("[TB] FAIL sh_timing: lat=%0d we_cyc=%0d want 3 2", lat, wc);
    end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'h5566_AA44) begin
      fails++; $display("[TB] FAIL sh_merge: got %h want 5566aa44", rd);
    end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd, wa, wd;
    logic        rf;
    int          lat, wc, wn;
    logic [2:0]  f3  [5];
    logic [31:0] ad  [5];
    logic [31:0] exp [5];
    f3[0] = 3'b000; ad[0] = 32'h0; exp[0] = 32'h0000_0001;
    f3[1] = 3'b000; ad[1] = 32'h3; exp[1] = 32'hFFFF_FF80;
    f3[2] = 3'b100; ad[2] = 32'h3; exp[2] = 32'h0000_0080;
    f3[3] = 3'b001; ad[3] = 32'h2; exp[3] = 32'hFFFF_80F0;
    f3[4] = 3'b101; ad[4] = 32'h2; exp[4] = 32'h0000_80F0;
    do_req(1'b1, 3'b010, 32'h0, 32'h80F0_7F01, rd, rf, lat, wc, wn, wa, wd);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3[i], ad[i], 32'h0, rd, rf, lat, wc, wn, wa, wd);
      tests++;
      if (rd !== exp[i] || rf !== 1'b0 || lat !== 2) begin
        fails++;
        $display("[TB] FAIL load_ext[%0d]: data=%h fault=%b lat=%0d want %h 0 2",
                 i, rd, rf, lat, exp[i]);
      end
    end
  endtask

  task automatic test_faults();
    logic [31:0] rd, wa, wd;
    logic        rf;
    int          lat, wc, wn;
    logic        fw [3];
    logic [2:0]  f3 [3];
    logic [31:0] ad [3];
    fw[0] = 1'b0; f3[0] = 3'b010; ad[0] = 32'h12;
    fw[1] = 1'b1; f3[1] = 3'b001; ad[1] = 32'h31;
    fw[2] = 1'b0; f3[2] = 3'b011; ad[2] = 32'h0;
    do_req(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, rd, rf, lat, wc, wn, wa, wd);
    for (int i = 0; i < 3; i++) begin
      do_req(fw[i], f3[i], ad[i], 32'hFFFF_FFFF, rd, rf, lat, wc, wn, wa, wd);
      tests++;
      if (rf !== 1'b1 || rd !== 32'h0 || lat !== 1 || wn !== 0) begin
        fails++;
        $display("[TB] FAIL fault[%0d]: fault=%b data=%h lat=%0d writes=%0d want 1 0 1 0",
                 i, rf, rd, lat, wn);
      end
    end
    do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'hCAFE_F00D) begin
      fails++; $display("[TB] FAIL fault_mem_30: got %h want cafef00d", rd);
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'hDEAD_BEEF) begin
      fails++; $display("[TB] FAIL fault_mem_10: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wa, wd;
    logic        rf;
    int          lat, wc, wn, acc0, guard;
    do_req(1'b1, 3'b010, 32'h48, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    acc0 = acc_cnt;
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqFunct3 = 3'b010;
    bus.ReqAddr = 32'h40; bus.ReqWData = 32'hAAAA_0001;
    @(posedge clk); #1;
    bus.ReqAddr = 32'h48; bus.ReqWData = 32'h0000_0BAD;
    tests++;
    if (bus.ReqReady !== 1'b0) begin
      fails++; $display("[TB] FAIL b2b_busy_ready: got %b want 0", bus.ReqReady);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.RespValid !== 1'b1 || bus.ReqReady !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_resp_cycle: rv=%b ready=%b want 1 0", bus.RespValid, bus.ReqReady);
    end
    @(posedge clk); #1;
    tests++;
    if (bus.ReqReady !== 1'b1) begin
      fails++; $display("[TB] FAIL b2b_idle_ready: got %b want 1", bus.ReqReady);
    end
    bus.ReqAddr = 32'h44; bus.ReqWData = 32'hBBBB_0002;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    guard = 0;
    while (!bus.RespValid && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    $display("[TB] B2B  two stores held valid -> accepts=%0d", acc_cnt - acc0);
    tests++;
    if (acc_cnt - acc0 !== 2 || guard >= 8) begin
      fails++; $display("[TB] FAIL b2b_accepts: got %0d want 2", acc_cnt - acc0);
    end
    do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'hAAAA_0001) begin
      fails++; $display("[TB] FAIL b2b_mem_40: got %h want aaaa0001", rd);
    end
    do_req(1'b0, 3'b010, 32'h44, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'hBBBB_0002) begin
      fails++; $display("[TB] FAIL b2b_mem_44: got %h want bbbb0002", rd);
    end
    do_req(1'b0, 3'b010, 32'h48, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'h0) begin
      fails++; $display("[TB] FAIL b2b_mem_48: got %h want 00000000", rd);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd, wa, wd;
    logic        rf;
    int          lat, wc, wn;
    do_req(1'b1, 3'b010, 32'h1000, 32'h0A11_A5ED, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (wa !== 32'h1000 || wn !== 1) begin
      fails++; $display("[TB] FAIL alias_memaddr: addr=%h writes=%0d want 00001000 1", wa, wn);
    end
    do_req(1'b0, 3'b010, 32'h0, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'h0A11_A5ED) begin
      fails++; $display("[TB] FAIL alias_word0: got %h want 0a11a5ed", rd);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd, wa, wd;
    logic        rf;
    int          lat, wc, wn;
    bit          saw_resp;
    do_req(1'b1, 3'b010, 32'h50, 32'h1234_5678, rd, rf, lat, wc, wn, wa, wd);
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqFunct3 = 3'b000;
    bus.ReqAddr = 32'h50; bus.ReqWData = 32'h0000_00FF;
    @(posedge clk); #1;
    bus.ReqValid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (bus.MemWriteEnable !== 1'b1) begin
      fails++; $display("[TB] FAIL rst_in_write_state: we=%b want 1", bus.MemWriteEnable);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (bus.MemWriteEnable !== 1'b0 || bus.MemWriteData !== 32'h0) begin
      fails++;
      $display("[TB] FAIL rst_write_gated: we=%b wd=%h want 0 0", bus.MemWriteEnable, bus.MemWriteData);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests++;
    if (bus.ReqReady !== 1'b1 || bus.RespValid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rst_release: ready=%b rv=%b want 1 0", bus.ReqReady, bus.RespValid);
    end
    saw_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.RespValid) saw_resp = 1'b1;
    end
    tests++;
    if (saw_resp !== 1'b0) begin
      fails++; $display("[TB] FAIL rst_no_resp: saw RespValid=%b want 0", saw_resp);
    end
    do_req(1'b0, 3'b010, 32'h50, 32'h0, rd, rf, lat, wc, wn, wa, wd);
    tests++;
    if (rd !== 32'h1234_5678) begin
      fails++; $display("[TB] FAIL rst_mem_unchanged: got %h want 12345678", rd);
    end
  endtask

  initial begin
    test_reset();
    test_word_roundtrip();
    test_subword_store();
    test_load_ext();
    test_faults();
    test_back_to_back();
    test_alias();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/lsu_controller.md
# lsu_controller

Load/store sequencer between the core's memory-stage request and the word-only data memory. It decodes RISC-V load/store width (byte, halfword, word; signed and unsigned) and performs sign or zero extension on loads. Sub-word stores are done as read-modify-write over the 32-bit write port. The block presents a valid/ready request handshake to the core and a one-cycle response pulse. It drives the data memory's WriteEnable, address and write-data inputs and consumes its combinational ReadData.

## Interface
- DEPTH_WORDS, 1024: data memory depth in 32-bit words. Must be a power of two.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ReqValid  in  1  core presents a request
- ReqReady  out  1  controller accepts a request this cycle
- ReqWrite  in  1  1 = store, 0 = load
- ReqFunct3  in  3  RISC-V funct3 of the load/store
- ReqAddr  in  32  byte address (ALUResult)
- ReqWData  in  32  store data (rs2), right-aligned
- RespValid  out  1  one-cycle completion pulse
- RespData  out  32  extended load data; 0 for stores and faults
- RespFault  out  1  valid with RespValid; misaligned access or illegal funct3
- MemWriteEnable  out  1  to data memory write enable
- MemAddr  out  32  to data memory byte address; the low 2 bits are always 0
- MemWriteData  out  32  to data memory write data
- MemReadData  in  32  from data memory; combinational read of MemAddr

## Operation
- Request handshake:
  - A request is accepted when ReqValid && ReqReady are high at a rising edge.
  - At acceptance the block latches ReqWrite, ReqFunct3, ReqAddr and ReqWData.
  - ReqReady = (state == IDLE) && !reset.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Transitions on accept from IDLE:
  - Fault → RESP.
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_READ.
- Other transitions: LOAD→RESP; RMW_READ→WRITE; WRITE→RESP; RESP→IDLE (unconditional).
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 is a fault.
- Alignment faults: halfword with Addr[0]=1; word with Addr[1:0]≠0. Byte accesses never fault.
- A fault never asserts MemWriteEnable.
- MemAddr = {latched Addr[31:2], 2'b00} in LOAD, RMW_READ and WRITE; 0 otherwise.
  - Memory index is Addr[log2(DEPTH_WORDS)+1:2]; upper bits alias (wrap modulo 4·DEPTH_WORDS bytes).
- LOAD:
  - Register MemReadData.
  - Select the lane by Addr[1:0]: byte lane = Addr[1:0]; halfword lane = Addr[1].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU; pass LW unchanged.
- RMW_READ: register MemReadData into merge buffer.
- WRITE:
  - MemWriteEnable = !reset.
  - SW: MemWriteData = ReqWData.
  - SB: MemWriteData = buffer with byte lane Addr[1:0] replaced by ReqWData[7:0].
  - SH: MemWriteData = buffer with halfword lane Addr[1] replaced by ReqWData[15:0].
- RESP:
  - RespValid = 1.
  - RespData = extended load value (loads) or 0.
  - RespFault as latched.
  - No backpressure on responses.
- MemWriteData is 0 outside WRITE. MemWriteEnable is 0 in every state except WRITE.

## Timing
- Reset:
  - Next edge with reset high forces IDLE and clears all latched request and buffer registers.
  - While reset is high: ReqReady=0, RespValid=0, RespData=0, RespFault=0, MemWriteEnable=0, MemAddr=0, MemWriteData=0.
  - Reset during WRITE suppresses the write in that same cycle (MemWriteEnable is gated).
  - Reset during RMW_READ or LOAD abandons the access with no memory side effect and no response.
- Latency, accept edge = cycle 0:
  - Fault: RespValid in cycle 1.
  - Load: cycle 2.
  - SW: MemWriteEnable in cycle 1, RespValid in cycle 2.
  - SB/SH: read in cycle 1, MemWriteEnable in cycle 2, RespValid in cycle 3.
- Throughput: ReqReady is low from cycle 1 through the RESP cycle. The next accept is at the earliest on the edge ending the first IDLE cycle after RESP.
- ReqValid while not ready is ignored (no latch). The core must hold the request until accepted.
- Request inputs may change freely after acceptance; the latched copies are used.
- Memory is written only on the edge that ends WRITE. Its value is visible on MemReadData from the next cycle.

## Test plan
- Word round trip:
  - SW Addr=0x10, Data=0xDEADBEEF → MemWriteEnable for exactly one cycle in cycle 1, MemAddr=0x10, response in cycle 2.
  - Then LW 0x10 → RespData=0xDEADBEEF, RespFault=0, RespValid in cycle 2.
- Sub-word store (memory word at 0x20 = 0x11223344):
  - SB Addr=0x21, Data=0xAA → word becomes 0x1122AA44, RespValid in cycle 3.
  - SH Addr=0x22, Data=0x5566 → word becomes 0x5566AA44.
- Load extension (word = 0x80F07F01):
  - LB 0x0 → 0x00000001; LB 0x3 → 0xFFFFFF80; LBU 0x3 → 0x00000080.
  - LH 0x2 → 0xFFFF80F0; LHU 0x2 → 0x000080F0.
- Faults:
  - LW 0x12, SH 0x31, and funct3=011 load → each gives RespFault=1, RespData=0, RespValid in cycle 1, MemWriteEnable never asserted.
  - Memory contents are unchanged.
- Handshake and aliasing:
  - ReqValid held high with back-to-back requests → exactly one accept per IDLE cycle; requests presented while busy are not latched.
  - SW at 0x1000 aliases to word 0 (DEPTH_WORDS=1024).
- Reset mid-operation:
  - Reset asserted in the WRITE cycle of an SB → memory unchanged, no RespValid, ReqReady=1 in the first cycle after reset deasserts.
